// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// hazard_scoreboard_pkg -- shared register-index and write-back arbiter definitions (Rev 1.0)
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W   = 6;
  localparam int NUM_REGS    = 1 << REG_IDX_W;
  localparam int FP_BANK_BIT = 0;
  localparam int DENY_CNT_W  = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT   = 2'd1,
    ARB_STARVE = 2'd2
  } arb_state_e;

  // The FP bank has no hardwired zero; only integer R0 is exempt from tracking.
  function automatic logic reg_trackable(input reg_idx_t idx);
    return idx[FP_BANK_BIT] || (idx != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_wb_arbiter.sv
`default_nettype none
// hazard_wb_arbiter -- shares the register write port between the fixed-latency pipe
// and the multi-cycle unit, with a starvation guard for the latter (Rev 1.0)
module hazard_wb_arbiter
  import hazard_scoreboard_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic long_done,
  input  logic pipe_wb_req,
  output logic long_ack,
  output logic starve
);

  if (STARVE_LIM < 1 || STARVE_LIM > 7) begin : g_bad_starve_lim
    $error("STARVE_LIM must lie in 1..7 to fit the deny counter");
  end

  localparam logic [DENY_CNT_W-1:0] STARVE_CNT = DENY_CNT_W'(STARVE_LIM);

  arb_state_e            state_q, state_d;
  logic [DENY_CNT_W-1:0] deny_cnt_q, deny_cnt_d;
  logic                  denied;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      deny_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      deny_cnt_q <= deny_cnt_d;
    end
  end

  always_comb begin
    long_ack   = long_done & ~pipe_wb_req & ~reset;
    denied     = long_done & pipe_wb_req;
    state_d    = state_q;
    deny_cnt_d = deny_cnt_q;
    starve     = (state_q == ARB_STARVE);

    if (long_ack) begin
      state_d    = ARB_IDLE;
      deny_cnt_d = '0;
    end else if (denied) begin
      case (state_q)
        ARB_STARVE: begin
          state_d = ARB_STARVE;
        end
        default: begin
          // The denial seen in IDLE is the first one counted.
          if (state_q == ARB_IDLE) begin
            deny_cnt_d = DENY_CNT_W'(1);
          end else if (deny_cnt_q != '1) begin
            deny_cnt_d = deny_cnt_q + DENY_CNT_W'(1);
          end
          state_d = (deny_cnt_d >= STARVE_CNT) ? ARB_STARVE : ARB_WAIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// hazard_scoreboard -- register busy tracking, RAW/WAW/long-unit issue interlock and
// register write-port steering (Rev 1.0)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IssueValid,
  input  logic [REG_IDX_W-1:0] IssueRs1,
  input  logic [REG_IDX_W-1:0] IssueRs2,
  input  logic                 IssueUsesRs1,
  input  logic                 IssueUsesRs2,
  input  logic                 IssueWritesRd,
  input  logic [REG_IDX_W-1:0] IssueRd,
  input  logic                 IssueLong,
  output logic                 Stall,
  input  logic                 PipeWBReq,
  input  logic [REG_IDX_W-1:0] PipeWBAddr,
  input  logic                 LongDone,
  input  logic [REG_IDX_W-1:0] LongAddr,
  output logic                 LongAck,
  output logic                 RegWBWE,
  output logic [REG_IDX_W-1:0] RegWBAddr,
  output logic                 RegWBSel
);

  if (PIPE_LAT < 1) begin : g_bad_pipe_lat
    $error("PIPE_LAT must be at least 1");
  end

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                long_busy_q, long_busy_d;
  logic                starve;
  logic                raw_hit, waw_hit, long_hit;
  logic                accept;

  hazard_wb_arbiter #(
    .STARVE_LIM (STARVE_LIM)
  ) u_wb_arbiter (
    .clk         (clk),
    .reset       (reset),
    .long_done   (LongDone),
    .pipe_wb_req (PipeWBReq),
    .long_ack    (LongAck),
    .starve      (starve)
  );

  // Hazards look only at registered busy state, so a same-cycle write-back
  // releases the stall one cycle later.
  always_comb begin
    raw_hit  = (IssueUsesRs1 & busy_q[IssueRs1]) | (IssueUsesRs2 & busy_q[IssueRs2]);
    waw_hit  = IssueWritesRd & busy_q[IssueRd];
    long_hit = IssueLong & long_busy_q;
    Stall    = ~reset & IssueValid & (raw_hit | waw_hit | long_hit | starve);
    accept   = IssueValid & ~Stall;

    RegWBWE   = ~reset & (PipeWBReq | LongAck);
    RegWBSel  = ~PipeWBReq;
    RegWBAddr = PipeWBReq ? PipeWBAddr : LongAddr;
  end

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (RegWBWE) begin
      busy_d[RegWBAddr] = 1'b0;
    end
    if (accept && IssueWritesRd && reg_trackable(IssueRd)) begin
      busy_d[IssueRd] = 1'b1;
    end

    long_busy_d = long_busy_q;
    if (LongAck) begin
      long_busy_d = 1'b0;
    end
    if (accept && IssueLong) begin
      long_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      long_busy_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      long_busy_q <= long_busy_d;
    end
  end

endmodule
`default_nettype wire
